// File: rtl/instr_queue_pkg.sv
// Types and sizing constants shared by decode, the instruction queue and issue.
package instr_queue_pkg;

  localparam int QDEPTH_DEF = 8;
  localparam int PTR_W_DEF  = $clog2(QDEPTH_DEF);
  localparam int CNT_W_DEF  = PTR_W_DEF + 1;

  // An all-zero entry (pc == 0) is the "nothing to issue" marker.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
  } decode_t;

  // The 2-bit request counts never mean more than two instructions.
  function automatic logic [1:0] sat2(input logic [1:0] n);
    return n[1] ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Decode/issue-facing bundle of the instruction queue.
interface instr_queue_if
  import instr_queue_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
);
  logic                      flush;
  logic [1:0]                push_cnt;
  decode_t [1:0]             push_instr;
  logic [1:0]                pop_cnt;
  decode_t [1:0]             head_instr;
  logic                      queue_empty;
  logic                      queue_full;
  logic [$clog2(QDEPTH):0]   count;

  modport master (
    output flush, push_cnt, push_instr, pop_cnt,
    input  head_instr, queue_empty, queue_full, count
  );

  modport slave (
    input  flush, push_cnt, push_instr, pop_cnt,
    output head_instr, queue_empty, queue_full, count
  );
endinterface

// File: rtl/instr_queue.sv
// Circular instruction queue between decode (up to 2 pushes) and issue (up to 2 pops).
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
) (
  input logic         clk,
  input logic         resetn,
  instr_queue_if.slave q
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  decode_t         mem [QDEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [1:0]      push_acc;
  logic [1:0]      pop_req;
  logic [1:0]      pop_eff;
  logic            full;

  assign full = count > CW'(QDEPTH - 2);

  always_comb begin
    push_acc = 2'd0;
    if (!full) push_acc = sat2(q.push_cnt);
    pop_req = sat2(q.pop_cnt);
    // pop_req exceeds count only when count is 0 or 1
    pop_eff = (CW'(pop_req) > count) ? count[1:0] : pop_req;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_acc != 2'd0) mem[tail] <= q.push_instr[0];
      if (push_acc == 2'd2) mem[tail + PW'(1)] <= q.push_instr[1];
      tail  <= tail + PW'(push_acc);
      head  <= head + PW'(pop_eff);
      count <= count + CW'(push_acc) - CW'(pop_eff);
    end
  end

  // Popped slots keep their old contents, so validity is masked by count here.
  always_comb begin
    q.head_instr[0] = '0;
    q.head_instr[1] = '0;
    if (count >= CW'(1)) q.head_instr[0] = mem[head];
    if (count >= CW'(2)) q.head_instr[1] = mem[head + PW'(1)];
  end

  assign q.count       = count;
  assign q.queue_empty = (count == '0);
  assign q.queue_full  = full;

endmodule
